// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Iterative HI/LO multiply/divide unit for the MIPS execute stage.
// It runs MULT/MULTU with a radix-2 shift-add and DIV/DIVU with a restoring
// shift-subtract. Each operation takes 32 iterations plus one sign-fix cycle.
// Results land in the HI/LO registers, which MTHI/MTLO can also load directly.
//
// Ports
//   CLK    in   1   rising-edge clock
//   RST_N  in   1   asynchronous active-low reset
//   START  in   1   begin an operation (sampled only while idle)
//   OP     in   2   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A      in  32   rs operand (multiplicand / dividend)
//   B      in  32   rt operand (multiplier / divisor)
//   HI_WE  in   1   MTHI write strobe (idle only)
//   LO_WE  in   1   MTLO write strobe (idle only)
//   WDATA  in  32   MTHI/MTLO data
//   BUSY   out  1   operation in progress
//   DONE   out  1   one-cycle pulse when HI/LO were just written by an operation
//   HI     out 32   HI register
//   LO     out 32   LO register
//
// Build option
//   MULDIV_DIV_EN  defined   : divider datapath present, all four ops work.
//                  undefined : no divider. DIV/DIVU pulse DONE right after the
//                              accepting edge and leave HI/LO untouched.
// -----------------------------------------------------------------------------
module mult_div_unit (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        START,
   input  logic [1:0]  OP,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        HI_WE,
   input  logic        LO_WE,
   input  logic [31:0] WDATA,
   output logic        BUSY,
   output logic        DONE,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   // Magnitude of a 32-bit operand; only signed negative values are negated.
   function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
      logic [31:0] r;
      if (is_signed && v[31]) begin
         r = ~v + 32'd1;
      end else begin
         r = v;
      end
      return r;
   endfunction

   // 32-bit two's complement negation.
   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

   // 64-bit two's complement negation.
   function automatic logic [63:0] neg64(input logic [63:0] v);
      return ~v + 64'd1;
   endfunction

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   // Multiply: {partial product high, multiplier/low product}.
   // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
   logic [63:0] acc_q, acc_d;
   // Multiplicand magnitude for multiply, divisor magnitude for divide.
   logic [31:0] opnd_q, opnd_d;
   logic        sign_a_q, sign_a_d;
   logic        sign_b_q, sign_b_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic [32:0] mul_sum_s;
   logic [63:0] prod_s;
`ifdef MULDIV_DIV_EN
   logic        div_q, div_d;
   logic [32:0] div_rsh_s;
   logic [32:0] div_diff_s;
   logic [31:0] quo_s;
   logic [31:0] rem_s;
`endif

   // Next-state, datapath iteration and output register inputs.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      sign_a_d  = sign_a_q;
      sign_b_d  = sign_b_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      hi_d      = hi_q;
      lo_d      = lo_q;
      mul_sum_s = 33'h0;
      prod_s    = 64'h0;
`ifdef MULDIV_DIV_EN
      div_d      = div_q;
      div_rsh_s  = 33'h0;
      div_diff_s = 33'h0;
      quo_s      = 32'h0;
      rem_s      = 32'h0;
`endif

      case (state_q)
         S_IDLE: begin
            if (START) begin
               // START beats a simultaneous MTHI/MTLO; the write is dropped.
               sign_a_d = ~OP[0] & A[31];
               sign_b_d = ~OP[0] & B[31];
`ifdef MULDIV_DIV_EN
               div_d   = OP[1];
               cnt_d   = 5'd0;
               busy_d  = 1'b1;
               state_d = S_CALC;
               if (OP[1]) begin
                  acc_d  = {32'h0, mag32(A, ~OP[0])};
                  opnd_d = mag32(B, ~OP[0]);
               end else begin
                  acc_d  = {32'h0, mag32(B, ~OP[0])};
                  opnd_d = mag32(A, ~OP[0]);
               end
`else
               if (OP[1]) begin
                  // No divider: acknowledge immediately, HI/LO untouched.
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  acc_d   = {32'h0, mag32(B, ~OP[0])};
                  opnd_d  = mag32(A, ~OP[0]);
                  cnt_d   = 5'd0;
                  busy_d  = 1'b1;
                  state_d = S_CALC;
               end
`endif
            end else begin
               if (HI_WE) begin
                  hi_d = WDATA;
               end else begin
                  hi_d = hi_q;
               end
               if (LO_WE) begin
                  lo_d = WDATA;
               end else begin
                  lo_d = lo_q;
               end
            end
         end

         S_CALC: begin
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = S_FIX;
            end else begin
               state_d = S_CALC;
            end
`ifdef MULDIV_DIV_EN
            if (div_q) begin
               // Restoring step: the remainder always stays below the divisor,
               // so bit 32 of the difference is a clean borrow flag.
               div_rsh_s  = {acc_q[63:32], acc_q[31]};
               div_diff_s = div_rsh_s - {1'b0, opnd_q};
               if (!div_diff_s[32]) begin
                  acc_d = {div_diff_s[31:0], acc_q[30:0], 1'b1};
               end else begin
                  acc_d = {div_rsh_s[31:0], acc_q[30:0], 1'b0};
               end
            end else begin
               mul_sum_s = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'h0);
               acc_d     = {mul_sum_s, acc_q[31:1]};
            end
`else
            mul_sum_s = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'h0);
            acc_d     = {mul_sum_s, acc_q[31:1]};
`endif
         end

         S_FIX: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`ifdef MULDIV_DIV_EN
            if (div_q) begin
               quo_s = acc_q[31:0];
               rem_s = acc_q[63:32];
               // With a zero divisor the remainder is the dividend magnitude,
               // so re-applying the dividend sign gives back raw A.
               hi_d = sign_a_q ? neg32(rem_s) : rem_s;
               if (opnd_q == 32'h0) begin
                  lo_d = 32'hFFFF_FFFF;
               end else begin
                  lo_d = (sign_a_q ^ sign_b_q) ? neg32(quo_s) : quo_s;
               end
            end else begin
               prod_s = (sign_a_q ^ sign_b_q) ? neg64(acc_q) : acc_q;
               hi_d   = prod_s[63:32];
               lo_d   = prod_s[31:0];
            end
`else
            prod_s = (sign_a_q ^ sign_b_q) ? neg64(acc_q) : acc_q;
            hi_d   = prod_s[63:32];
            lo_d   = prod_s[31:0];
`endif
         end

         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any operation and clears HI/LO.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         cnt_q    <= 5'd0;
         acc_q    <= 64'h0;
         opnd_q   <= 32'h0;
         sign_a_q <= 1'b0;
         sign_b_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         hi_q     <= 32'h0;
         lo_q     <= 32'h0;
`ifdef MULDIV_DIV_EN
         div_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         sign_a_q <= sign_a_d;
         sign_b_q <= sign_b_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
`ifdef MULDIV_DIV_EN
         div_q    <= div_d;
`endif
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign HI   = hi_q;
   assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//
// Self-checking bench for mult_div_unit. The expected HI/LO of every operation
// come from a native-arithmetic reference model. They are pushed to a
// scoreboard when START is driven and popped when DONE is seen. Latency, BUSY
// width, ignored inputs, MTHI/MTLO writes and mid-operation reset are also
// checked. Expectations follow MULDIV_DIV_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

   logic        CLK;
   logic        RST_N;
   logic        START;
   logic [1:0]  OP;
   logic [31:0] A;
   logic [31:0] B;
   logic        HI_WE;
   logic        LO_WE;
   logic [31:0] WDATA;
   logic        BUSY;
   logic        DONE;
   logic [31:0] HI;
   logic [31:0] LO;

   int          n_checks;
   int          n_errors;
   logic [63:0] sb_q[$];
   logic [31:0] hi_m;
   logic [31:0] lo_m;

   mult_div_unit dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .START (START),
      .OP    (OP),
      .A     (A),
      .B     (B),
      .HI_WE (HI_WE),
      .LO_WE (LO_WE),
      .WDATA (WDATA),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .HI    (HI),
      .LO    (LO)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Reference model: {HI, LO} after an operation, using native arithmetic.
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      logic [63:0] res;
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      case (op)
         2'b00: res = 64'(sa * sb);
         2'b01: res = {32'h0, a} * {32'h0, b};
         2'b10: begin
            if (b == 32'h0) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               q   = sa / sb;
               r   = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 32'h0) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               res = {a % b, a / b};
            end
         end
      endcase
`ifndef MULDIV_DIV_EN
      if (op[1]) res = {hi_m, lo_m};
`endif
      return res;
   endfunction

   // Issue one operation and follow it to DONE. Ends in the DONE cycle.
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit disturb, input bit wr_start);
      logic [63:0] exp;
      int k;
      int busy_n;
      int exp_lat;
      chk("idle_before_start", 64'(BUSY), 64'h0);
      sb_q.push_back(model(op, a, b));
      START = 1'b1;
      OP    = op;
      A     = a;
      B     = b;
      if (wr_start) begin
         HI_WE = 1'b1;
         LO_WE = 1'b1;
         WDATA = 32'hDEAD_BEEF;
      end
      tick();
      START = 1'b0;
      HI_WE = 1'b0;
      LO_WE = 1'b0;
      A     = $urandom;
      B     = $urandom;
      OP    = 2'($urandom_range(3, 0));
      k      = 0;
      busy_n = 0;
      while (k < 100 && !DONE) begin
         if (BUSY) busy_n++;
         if (disturb && k == 5) begin
            START = 1'b1;
            OP    = 2'b01;
            A     = 32'h0000_0003;
            B     = 32'h0000_0005;
            HI_WE = 1'b1;
            LO_WE = 1'b1;
            WDATA = 32'h1234_5678;
         end
         if (disturb && k == 6) begin
            START = 1'b0;
            HI_WE = 1'b0;
            LO_WE = 1'b0;
         end
         tick();
         k++;
      end
      START = 1'b0;
      HI_WE = 1'b0;
      LO_WE = 1'b0;
      exp_lat = 33;
`ifndef MULDIV_DIV_EN
      if (op[1]) exp_lat = 0;
`endif
      chk("done_latency", 64'(k), 64'(exp_lat));
      chk("busy_cycles", 64'(busy_n), 64'(exp_lat));
      if (DONE) begin
         chk("busy_at_done", 64'(BUSY), 64'h0);
         chk("sb_depth", 64'(sb_q.size()), 64'h1);
         if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            chk("hi_result", 64'(HI), 64'(exp[63:32]));
            chk("lo_result", 64'(LO), 64'(exp[31:0]));
            hi_m = exp[63:32];
            lo_m = exp[31:0];
         end
      end else begin
         sb_q.delete();
      end
   endtask

   // One idle cycle; DONE must have dropped and HI/LO must hold.
   task automatic idle_tick();
      tick();
      chk("done_dropped", 64'(DONE), 64'h0);
      chk("busy_idle", 64'(BUSY), 64'h0);
      chk("hold_hilo", {HI, LO}, {hi_m, lo_m});
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      hi_m  = 32'h0;
      lo_m  = 32'h0;
      RST_N = 1'b0;
      START = 1'b0;
      OP    = 2'b00;
      A     = 32'h0;
      B     = 32'h0;
      HI_WE = 1'b0;
      LO_WE = 1'b0;
      WDATA = 32'h0;
      #12;
      chk("rst_busy", 64'(BUSY), 64'h0);
      chk("rst_done", 64'(DONE), 64'h0);
      chk("rst_hilo", {HI, LO}, 64'h0);
      RST_N = 1'b1;
      tick();

      // Signed multiply while new START and MTHI/MTLO attempts are ignored.
      run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 1'b0);
      chk("tp_mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
      idle_tick();

      // MULTU, then MULT back-to-back in the DONE cycle.
      run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("tp_multu_max", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      chk("tp_mult_m1", {HI, LO}, 64'h0000_0000_0000_0001);
      idle_tick();

      // Divides, including zero divisor and the overflow case.
      run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0, 1'b0);
`ifdef MULDIV_DIV_EN
      chk("tp_div_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
`endif
      run_op(2'b11, 32'd100, 32'h0, 1'b0, 1'b0);
`ifdef MULDIV_DIV_EN
      chk("tp_divu_zero", {HI, LO}, 64'h0000_0064_FFFF_FFFF);
`endif
      run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
`ifdef MULDIV_DIV_EN
      chk("tp_div_ovf", {HI, LO}, 64'h0000_0000_8000_0000);
`endif
      run_op(2'b10, 32'hFFFF_FFFB, 32'h0, 1'b0, 1'b0);
      idle_tick();

      // MTHI alone, then both strobes together.
      HI_WE = 1'b1;
      WDATA = 32'h1234_5678;
      tick();
      HI_WE = 1'b0;
      hi_m  = 32'h1234_5678;
      chk("mthi", 64'(HI), 64'h0000_0000_1234_5678);
      chk("mthi_lo_kept", 64'(LO), 64'(lo_m));
      HI_WE = 1'b1;
      LO_WE = 1'b1;
      WDATA = 32'hCAFE_F00D;
      tick();
      HI_WE = 1'b0;
      LO_WE = 1'b0;
      hi_m  = 32'hCAFE_F00D;
      lo_m  = 32'hCAFE_F00D;
      chk("mthi_mtlo", {HI, LO}, {hi_m, lo_m});

      // START together with a write: START wins, write dropped.
      run_op(2'b11, 32'd100, 32'd5, 1'b0, 1'b1);
      idle_tick();
      run_op(2'b00, 32'h0000_0006, 32'hFFFF_FFF9, 1'b0, 1'b1);
      idle_tick();

      // Random operands over all ops.
      for (int i = 0; i < 8; i++) begin
         logic [31:0] ra;
         logic [31:0] rb;
         ra = $urandom;
         rb = (i == 3) ? 32'h0 : $urandom;
         if (i == 5) rb = 32'($urandom_range(9, 1));
         run_op(2'(i % 4), ra, rb, 1'b0, 1'b0);
      end
      idle_tick();

      // Reset ten cycles into a multiply.
      START = 1'b1;
      OP    = 2'b00;
      A     = 32'h0001_2345;
      B     = 32'h0000_0077;
      tick();
      START = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      #2;
      RST_N = 1'b0;
      #1;
      chk("midrst_busy", 64'(BUSY), 64'h0);
      chk("midrst_done", 64'(DONE), 64'h0);
      chk("midrst_hilo", {HI, LO}, 64'h0);
      hi_m = 32'h0;
      lo_m = 32'h0;
      tick();
      tick();
      RST_N = 1'b1;
      tick();
      chk("postrst_busy", 64'(BUSY), 64'h0);
      run_op(2'b01, 32'd6, 32'd7, 1'b0, 1'b0);
      chk("tp_multu_42", {HI, LO}, 64'd42);
      idle_tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
